// File: rtl/ahb_lsu_sequencer.sv
// Load/store sequencer: one RV32 core memory request becomes one AHB-Lite NONSEQ transfer.
// Optional data-phase HREADY-low watchdog is enabled by defining AHB_TIMEOUT_EN.
module ahb_lsu_sequencer #(
    parameter logic [3:0] HPROT_DATA     = 4'b0001,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR,
        S_DONE
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must fit the 8-bit hready-low counter");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;

    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        bus_err_q, bus_err_d;

`ifdef AHB_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [7:0]  to_cnt_inc;
    logic        to_expired;
`endif

    logic        req_any;
    logic        req_illegal;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic [31:0] st_lanes;

    assign req_any = req_read | req_write;

    // Encodings that can never reach the bus; req_write decides direction since writes win.
    always_comb begin
        req_illegal = 1'b0;
        case (req_func3)
            3'b000:  req_illegal = 1'b0;
            3'b001:  req_illegal = req_addr[0];
            3'b010:  req_illegal = |req_addr[1:0];
            3'b100:  req_illegal = req_write;
            3'b101:  req_illegal = req_write | req_addr[0];
            default: req_illegal = 1'b1;
        endcase
    end

    assign rd_shifted = hrdata >> {addr_lo_q, 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = addr_lo_q[1] ? hrdata[31:16] : hrdata[15:0];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   rd_ext = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
            default: rd_ext = hrdata;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   st_lanes = {4{wdata_q[7:0]}};
            2'b01:   st_lanes = {2{wdata_q[15:0]}};
            default: st_lanes = wdata_q;
        endcase
    end

`ifdef AHB_TIMEOUT_EN
    assign to_cnt_inc = to_cnt_q + 8'd1;
    assign to_expired = !hready && (to_cnt_inc == 8'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
`ifdef AHB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    f3_d      = req_func3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    wr_d      = req_write;
                    if (req_illegal) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = {1'b0, req_func3[1:0]};
                    end
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = st_lanes;
`ifdef AHB_TIMEOUT_EN
                    to_cnt_d = 8'd0;
`endif
                end
            end
            S_DATA: begin
`ifdef AHB_TIMEOUT_EN
                if (!hready) to_cnt_d = to_cnt_inc;
`endif
                if (hready) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    // An ERROR seen with hready high is malformed; report it rather than lose it.
                    if (hresp) begin
                        bus_err_d = 1'b1;
                    end else if (!wr_q) begin
                        load_data_d = rd_ext;
                    end
                end else if (hresp) begin
                    state_d = S_ERR;
                end
`ifdef AHB_TIMEOUT_EN
                if (to_expired) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end
`endif
            end
            S_ERR: begin
`ifdef AHB_TIMEOUT_EN
                if (!hready) to_cnt_d = to_cnt_inc;
                if (hready || to_expired) begin
`else
                if (hready) begin
`endif
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            f3_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            wdata_q     <= 32'h0;
            wr_q        <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= 32'h0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hwdata_q    <= 32'h0;
            load_data_q <= 32'h0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef AHB_TIMEOUT_EN
            to_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
`ifdef AHB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // The only combinational output: the core must freeze in the very cycle it issues a request.
    assign stall = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                   ((state_q == S_IDLE) && req_any);

    assign done      = done_q;
    assign bus_err   = bus_err_q;
    assign load_data = load_data_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hprot     = HPROT_DATA;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_lsu_sequencer.sv
// Directed bench for ahb_lsu_sequencer: one task per scenario, inline expected-value checks.
module tb_ahb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        bus_err;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata = 32'h0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int checks = 0;
    int failures = 0;

    // Observations of the most recent transaction, filled by do_txn.
    int          t_done_cyc;
    logic        t_berr;
    logic [31:0] t_ld;
    logic        t_nonseq;
    logic [31:0] t_haddr;
    logic [2:0]  t_hsize;
    logic        t_hwrite;
    logic [31:0] t_hwdata;
    logic        t_stall_ok;

    always #5 clk = ~clk;

    ahb_lsu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_read  (req_read),
        .req_write (req_write),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .bus_err   (bus_err),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    // Drives one request and plays the AHB slave; cycle 0 is the accept cycle.
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits, input logic err_resp);
        int cyc;
        int data_k;
        logic in_addr;
        t_done_cyc = -1; t_berr = 1'b0; t_ld = 32'hx; t_nonseq = 1'b0;
        t_haddr = 32'hx; t_hsize = 3'bx; t_hwrite = 1'bx; t_hwdata = 32'hx; t_stall_ok = 1'b1;
        @(posedge clk); #1;
        req_read = rd; req_write = wr; req_func3 = f3; req_addr = a; req_wdata = wd;
        hrdata = rdat; hready = 1'b1; hresp = 1'b0;
        cyc = 0; data_k = -1;
        #1;
        while (cyc < 40) begin
            in_addr = (htrans == 2'b10);
            if (in_addr) begin
                t_nonseq = 1'b1; t_haddr = haddr; t_hsize = hsize; t_hwrite = hwrite;
            end
            if (data_k >= 0) t_hwdata = hwdata;
            if (done === 1'b1) begin
                t_done_cyc = cyc; t_berr = bus_err; t_ld = load_data;
                if (stall !== 1'b0) t_stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) t_stall_ok = 1'b0;
            if (data_k >= 0) begin
                if (err_resp) begin hready = (data_k >= 1); hresp = 1'b1; end
                else          begin hready = (data_k >= waits); hresp = 1'b0; end
            end else begin
                hready = 1'b1; hresp = 1'b0;
            end
            data_k = in_addr ? 0 : ((data_k >= 0) ? data_k + 1 : -1);
            @(posedge clk); #2;
            cyc++;
        end
        req_read = 1'b0; req_write = 1'b0; hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", htrans); end
        checks++; if (haddr !== 32'h0 || hwrite !== 1'b0 || hsize !== 3'b000 || hwdata !== 32'h0) begin
            failures++; $display("FAIL reset_bus got haddr=%h hwrite=%b hsize=%b hwdata=%h exp all zero", haddr, hwrite, hsize, hwdata); end
        checks++; if (load_data !== 32'h0 || done !== 1'b0 || bus_err !== 1'b0) begin
            failures++; $display("FAIL reset_core got ld=%h done=%b err=%b exp 0/0/0", load_data, done, bus_err); end
        checks++; if (hprot !== 4'b0001) begin failures++; $display("FAIL reset_hprot got=%b exp=0001", hprot); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_lw();
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        $display("txn LW addr=00001004 done_cyc=%0d ld=%h", t_done_cyc, t_ld);
        checks++; if (t_haddr !== 32'h0000_1004 || t_hsize !== 3'b010 || t_hwrite !== 1'b0) begin
            failures++; $display("FAIL lw_addr_phase got haddr=%h hsize=%b hwrite=%b exp 00001004/010/0", t_haddr, t_hsize, t_hwrite); end
        checks++; if (t_done_cyc != 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", t_done_cyc); end
        checks++; if (t_ld !== 32'hDEAD_BEEF || t_berr !== 1'b0) begin
            failures++; $display("FAIL lw_data got ld=%h err=%b exp DEADBEEF/0", t_ld, t_berr); end
        checks++; if (t_stall_ok !== 1'b1) begin failures++; $display("FAIL lw_stall got=%b exp=1", t_stall_ok); end
        checks++; if (hprot !== 4'b0001) begin failures++; $display("FAIL lw_hprot got=%b exp=0001", hprot); end
    endtask

    task automatic test_lb_lbu();
        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0);
        $display("txn LB addr=00001003 ld=%h", t_ld);
        checks++; if (t_ld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", t_ld); end
        checks++; if (t_hsize !== 3'b000) begin failures++; $display("FAIL lb_hsize got=%b exp=000", t_hsize); end
        do_txn(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0);
        $display("txn LBU addr=00001003 ld=%h", t_ld);
        checks++; if (t_ld !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", t_ld); end
        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h1234_7F56, 0, 1'b0);
        $display("txn LB addr=00001001 ld=%h", t_ld);
        checks++; if (t_ld !== 32'h0000_007F) begin failures++; $display("FAIL lb_lane1 got=%h exp=0000007f", t_ld); end
    endtask

    task automatic test_lh_lhu();
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 1, 1'b0);
        $display("txn LH addr=00000002 ld=%h done_cyc=%0d", t_ld, t_done_cyc);
        checks++; if (t_ld !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_sext got=%h exp=ffff8001", t_ld); end
        checks++; if (t_done_cyc != 4) begin failures++; $display("FAIL lh_wait_latency got=%0d exp=4", t_done_cyc); end
        do_txn(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 1'b0);
        $display("txn LHU addr=00000002 ld=%h", t_ld);
        checks++; if (t_ld !== 32'h0000_8001) begin failures++; $display("FAIL lhu_zext got=%h exp=00008001", t_ld); end
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h8001_7FFE, 0, 1'b0);
        $display("txn LH addr=00000000 ld=%h", t_ld);
        checks++; if (t_ld !== 32'h0000_7FFE) begin failures++; $display("FAIL lh_low got=%h exp=00007ffe", t_ld); end
    endtask

    task automatic test_store_half();
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2, 1'b0);
        $display("txn SH addr=00002002 hwdata=%h done_cyc=%0d", t_hwdata, t_done_cyc);
        checks++; if (t_hwdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_hwdata got=%h exp=abcdabcd", t_hwdata); end
        checks++; if (t_hwrite !== 1'b1 || t_hsize !== 3'b001) begin
            failures++; $display("FAIL sh_ctrl got hwrite=%b hsize=%b exp 1/001", t_hwrite, t_hsize); end
        checks++; if (t_done_cyc != 5 || t_berr !== 1'b0) begin
            failures++; $display("FAIL sh_done got cyc=%0d err=%b exp 5/0", t_done_cyc, t_berr); end
        checks++; if (t_stall_ok !== 1'b1) begin failures++; $display("FAIL sh_stall got=%b exp=1", t_stall_ok); end
    endtask

    task automatic test_write_wins();
        do_txn(1'b1, 1'b1, 3'b000, 32'h0000_5001, 32'hFFFF_FF5A, 32'h0, 0, 1'b0);
        $display("txn SB(rd+wr) addr=00005001 hwdata=%h hwrite=%b", t_hwdata, t_hwrite);
        checks++; if (t_hwrite !== 1'b1) begin failures++; $display("FAIL ww_hwrite got=%b exp=1", t_hwrite); end
        checks++; if (t_hwdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL ww_hwdata got=%h exp=5a5a5a5a", t_hwdata); end
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        $display("txn SW addr=00005004 hwdata=%h", t_hwdata);
        checks++; if (t_hwdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL sw_hwdata got=%h exp=cafef00d", t_hwdata); end
    endtask

    task automatic test_illegal();
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
        $display("txn LH addr=00003001 (misaligned) done_cyc=%0d err=%b", t_done_cyc, t_berr);
        checks++; if (t_nonseq !== 1'b0) begin failures++; $display("FAIL ill_lh_nonseq got=%b exp=0", t_nonseq); end
        checks++; if (t_done_cyc != 1 || t_berr !== 1'b1) begin
            failures++; $display("FAIL ill_lh_done got cyc=%0d err=%b exp 1/1", t_done_cyc, t_berr); end
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 1'b0);
        $display("txn LW addr=00001002 (misaligned) err=%b", t_berr);
        checks++; if (t_nonseq !== 1'b0 || t_berr !== 1'b1 || t_done_cyc != 1) begin
            failures++; $display("FAIL ill_lw got nonseq=%b err=%b cyc=%0d exp 0/1/1", t_nonseq, t_berr, t_done_cyc); end
        do_txn(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
        $display("txn SBU-encoding addr=00001000 err=%b", t_berr);
        checks++; if (t_nonseq !== 1'b0 || t_berr !== 1'b1) begin
            failures++; $display("FAIL ill_store_f3 got nonseq=%b err=%b exp 0/1", t_nonseq, t_berr); end
        do_txn(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
        $display("txn func3=011 err=%b", t_berr);
        checks++; if (t_nonseq !== 1'b0 || t_berr !== 1'b1) begin
            failures++; $display("FAIL ill_f3_011 got nonseq=%b err=%b exp 0/1", t_nonseq, t_berr); end
    endtask

    task automatic test_bus_error();
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_2468, 0, 1'b0);
        $display("txn LW addr=00006000 ld=%h", t_ld);
        checks++; if (t_ld !== 32'h1357_2468) begin failures++; $display("FAIL berr_pre got=%h exp=13572468", t_ld); end
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'hFFFF_FFFF, 0, 1'b1);
        $display("txn LW addr=00006004 (ERROR resp) done_cyc=%0d err=%b ld=%h", t_done_cyc, t_berr, t_ld);
        checks++; if (t_berr !== 1'b1 || t_done_cyc != 4) begin
            failures++; $display("FAIL berr_flag got err=%b cyc=%0d exp 1/4", t_berr, t_done_cyc); end
        checks++; if (t_ld !== 32'h1357_2468) begin failures++; $display("FAIL berr_ld_kept got=%h exp=13572468", t_ld); end
        checks++; if (t_nonseq !== 1'b1) begin failures++; $display("FAIL berr_nonseq got=%b exp=1", t_nonseq); end
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h0102_0304, 0, 1'b0);
        $display("txn LW addr=00007000 ld=%h", t_ld);
        @(posedge clk); #2;
        checks++; if (done !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL b2b_pulse_clear got done=%b err=%b stall=%b exp 0/0/0", done, bus_err, stall); end
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'h0, 32'hA5A5_0F0F, 0, 1'b0);
        $display("txn LW addr=00007004 ld=%h done_cyc=%0d", t_ld, t_done_cyc);
        checks++; if (t_ld !== 32'hA5A5_0F0F || t_done_cyc != 3 || t_haddr !== 32'h0000_7004) begin
            failures++; $display("FAIL b2b_second got ld=%h cyc=%0d haddr=%h exp a5a50f0f/3/00007004", t_ld, t_done_cyc, t_haddr); end
    endtask

    task automatic test_reset_mid_addr();
        logic seen_done;
        seen_done = 1'b0;
        @(posedge clk); #1;
        req_read = 1'b1; req_func3 = 3'b010; req_addr = 32'h0000_4000; hready = 1'b0;
        @(posedge clk); #2;
        checks++; if (htrans !== 2'b10) begin failures++; $display("FAIL rst_mid_nonseq got=%b exp=10", htrans); end
        reset = 1'b0;
        #1;
        $display("txn reset asserted mid-ADDR htrans=%b", htrans);
        checks++; if (htrans !== 2'b00) begin failures++; $display("FAIL rst_mid_htrans got=%b exp=00", htrans); end
        req_read = 1'b0; hready = 1'b1;
        repeat (2) begin @(posedge clk); #2; if (done === 1'b1) seen_done = 1'b1; end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) begin @(posedge clk); #2; if (done === 1'b1) seen_done = 1'b1; end
        checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=0", seen_done); end
    endtask

`ifdef AHB_TIMEOUT_EN
    task automatic test_timeout();
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 1000, 1'b0);
        $display("txn LW addr=00008000 (hready stuck) done_cyc=%0d err=%b", t_done_cyc, t_berr);
        checks++; if (t_done_cyc != 18 || t_berr !== 1'b1) begin
            failures++; $display("FAIL timeout got cyc=%0d err=%b exp 18/1", t_done_cyc, t_berr); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_lh_lhu();
        test_store_half();
        test_write_wins();
        test_illegal();
        test_bus_error();
        test_back_to_back();
        test_reset_mid_addr();
`ifdef AHB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
